dual_port_ram: RTL and testbench
================================

DUAL_PORT_RAM -- requirements
Module: dual_port_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 64, data word width.
REQ-002 SHALL have parameter ADDR_W, default 12, address width; DEPTH = 2**ADDR_W (4096).
REQ-003 SHALL have port clock, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port data_in, input, DATA_W, write data.
REQ-006 SHALL have port wrt_address, input, ADDR_W, write address.
REQ-007 SHALL have port write, input, 1, write request; sampled each edge.
REQ-008 SHALL have port rd_address, input, ADDR_W, read address.
REQ-009 SHALL have port read, input, 1, read request; sampled each edge.
REQ-010 SHALL have port data_out, output, DATA_W, read data, registered.
REQ-011 SHALL have port rd_valid, output, 1, data_out carries the result of a read this cycle.
REQ-012 SHALL have port rd_uninit, output, 1, the returned read targeted a never-written address; qualified by rd_valid.

Function
REQ-013 SHALL write data_in to mem[wrt_address] at every edge where write=1; no backpressure, every request accepted.
REQ-014 SHALL process reads in a 2-stage pipeline: stage 1 captures the addressed word at edge N; stage 2 registers data_out, rd_valid and rd_uninit at edge N+1. Read latency is 2 edges and throughput 1 read per cycle.
REQ-015 SHALL make a read sampled at edge N return the memory state after all writes sampled at or before edge N.
REQ-016 SHALL, on a read and a write at the same address at the same edge, return data_in (write-first bypass) with rd_uninit=0.
REQ-017 SHALL NOT let a write sampled at edge N+1 or later alter a read already captured at edge N.
REQ-018 SHALL keep a DEPTH-bit written map; a write sets bit[wrt_address].
REQ-019 SHALL return data_out=0 and rd_uninit=1 for a read of an address whose map bit is clear (no same-edge bypass).
REQ-020 SHALL hold data_out and rd_uninit at their last values and drive rd_valid=0 in cycles with no read result.
REQ-021 SHALL keep read and write ports independent; simultaneous accesses to different addresses proceed with no interaction.
REQ-022 SHALL wrap address arithmetic only in the testbench; the RAM decodes the full ADDR_W range and has no out-of-range case.

Reset
REQ-023 SHALL, while resetn=0, force data_out=0, rd_valid=0, rd_uninit=0, clear both pipeline stages and clear the entire written map.
REQ-024 SHALL NOT reset the memory array; the cleared map makes stale contents unobservable.
REQ-025 SHALL discard reads in flight when reset is asserted mid-operation; no rd_valid pulse SHALL appear for them after release.
REQ-026 SHALL ignore write and read on the first edge after resetn deasserts only if resetn is still low at that edge; requests SHALL be accepted from the first edge with resetn=1.

Structure
REQ-027 SHALL take DATA_W, ADDR_W, DEPTH and typedefs data_t/addr_t from shared package ram_pkg, also used by ram_if and the testbench.
REQ-028 SHALL place the storage array and written map in one sub-module ram_mem_array: 1 write port, 1 combinational read port, map-bit output. Pipeline, bypass and output registers SHALL stay in dual_port_ram.

Verification
REQ-029 Write 0xDEAD_BEEF_0000_0001 to addr 0x010, then read 0x010 -> data_out=0xDEAD_BEEF_0000_0001, rd_valid=1, rd_uninit=0 exactly 2 edges after the read.
REQ-030 Read addr 0xFFF after reset with no prior write -> data_out=0, rd_uninit=1, rd_valid=1.
REQ-031 Same-edge write 0x1234 and read at addr 0x0AB, old value 0x5555 -> data_out=0x1234.
REQ-032 Read addr 0x020 (holds 0x1) at edge N, write 0x2 to 0x020 at edge N+1 -> data_out=0x1; a later read returns 0x2.
REQ-033 Back-to-back reads of addrs 0..7 on consecutive edges after writing value=addr -> rd_valid high for 8 consecutive cycles with data_out 0..7 in order.
REQ-034 Assert resetn=0 with 2 reads in flight, then release -> no rd_valid pulse; a read of a previously written addr returns rd_uninit=1, data_out=0.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared widths and word/address types for the dual-port RAM, its bus and bench.
package ram_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage : ram_pkg

// File: rtl/ram_if.sv
// Write/read request bus and read-result bus of the dual-port RAM.
interface ram_if;
  import ram_pkg::*;

  data_t data_in;
  addr_t wrt_address;
  logic  write;
  addr_t rd_address;
  logic  read;
  data_t data_out;
  logic  rd_valid;
  logic  rd_uninit;

  // Requester side: issues writes/reads, receives read results.
  modport master (
    output data_in, wrt_address, write, rd_address, read,
    input  data_out, rd_valid, rd_uninit
  );

  // RAM side.
  modport slave (
    input  data_in, wrt_address, write, rd_address, read,
    output data_out, rd_valid, rd_uninit
  );

endinterface : ram_if

// File: rtl/ram_mem_array.sv
// Storage array plus per-address written map; one write port, one async read port.
module ram_mem_array #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_word_c,
  output logic              rd_written_c
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  written;

  // Array has no reset; writes while in reset are dropped.
  always_ff @(posedge clk) begin
    if (wr_en && rst_n) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Written map: cleared by reset, one bit set per accepted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written <= '0;
    end else if (wr_en) begin
      written[wr_addr] <= 1'b1;
    end
  end

  assign rd_word_c    = mem[rd_addr];
  assign rd_written_c = written[rd_addr];

endmodule : ram_mem_array

// File: rtl/dual_port_ram.sv
// Dual-port RAM: independent write port and 2-stage pipelined read port
// with write-first same-address bypass and never-written detection.
module dual_port_ram #(
  parameter int unsigned DATA_W = ram_pkg::DATA_W,
  parameter int unsigned ADDR_W = ram_pkg::ADDR_W
) (
  input logic  clock,
  input logic  resetn,
  ram_if.slave bus
);

  logic [DATA_W-1:0] mem_word_c;
  logic              mem_written_c;
  logic              bypass_c;
  logic [DATA_W-1:0] s1_data_c;
  logic              s1_uninit_c;

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic              s1_uninit;

  logic [DATA_W-1:0] data_out_q;
  logic              rd_valid_q;
  logic              rd_uninit_q;

  ram_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk          (clock),
    .rst_n        (resetn),
    .wr_en        (bus.write),
    .wr_addr      (bus.wrt_address),
    .wr_data      (bus.data_in),
    .rd_addr      (bus.rd_address),
    .rd_word_c    (mem_word_c),
    .rd_written_c (mem_written_c)
  );

  // Stage-1 word select: same-edge write wins, never-written reads return zero.
  always_comb begin
    bypass_c    = bus.read && bus.write && (bus.rd_address == bus.wrt_address);
    s1_data_c   = '0;
    s1_uninit_c = 1'b0;
    if (bypass_c) begin
      s1_data_c = bus.data_in;
    end else if (mem_written_c) begin
      s1_data_c = mem_word_c;
    end else begin
      s1_uninit_c = 1'b1;
    end
  end

  // Stage 1: capture the addressed word so later writes cannot disturb it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_uninit <= 1'b0;
    end else begin
      s1_valid <= bus.read;
      if (bus.read) begin
        s1_data   <= s1_data_c;
        s1_uninit <= s1_uninit_c;
      end
    end
  end

  // Stage 2: output registers; data and uninit flag hold between results.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      data_out_q  <= '0;
      rd_valid_q  <= 1'b0;
      rd_uninit_q <= 1'b0;
    end else begin
      rd_valid_q <= s1_valid;
      if (s1_valid) begin
        data_out_q  <= s1_data;
        rd_uninit_q <= s1_uninit;
      end
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_uninit = rd_uninit_q;

endmodule : dual_port_ram

// File: tb/tb_dual_port_ram.sv
// Directed self-checking bench for dual_port_ram.
module tb_dual_port_ram;
  import ram_pkg::*;

  logic clock;
  logic resetn;
  int   checks;
  int   errors;

  ram_if bus ();

  dual_port_ram dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input data_t obs, input data_t exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.write       = 1'b0;
    bus.read        = 1'b0;
    bus.data_in     = '0;
    bus.wrt_address = '0;
    bus.rd_address  = '0;
  endtask

  task automatic do_write(input addr_t a, input data_t d);
    bus.write       = 1'b1;
    bus.wrt_address = a;
    bus.data_in     = d;
    step();
    bus.write = 1'b0;
  endtask

  // Issue one read, wait for its result and check it.
  task automatic do_read(input string tag, input addr_t a, input data_t exp_d, input logic exp_u);
    bus.read       = 1'b1;
    bus.rd_address = a;
    step();
    bus.read = 1'b0;
    chk({tag, "_lat1_valid"}, data_t'(bus.rd_valid), data_t'(1'b0));
    step();
    chk({tag, "_valid"}, data_t'(bus.rd_valid), data_t'(1'b1));
    chk({tag, "_data"}, bus.data_out, exp_d);
    chk({tag, "_uninit"}, data_t'(bus.rd_uninit), data_t'(exp_u));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    resetn = 1'b0;

    // Reset state
    step(); step(); step();
    chk("rst_data", bus.data_out, '0);
    chk("rst_valid", data_t'(bus.rd_valid), '0);
    chk("rst_uninit", data_t'(bus.rd_uninit), '0);
    resetn = 1'b1;

    // Never-written top address
    do_read("uninit_fff", 12'hFFF, '0, 1'b1);

    // Plain write then read, then hold behaviour
    do_write(12'h010, 64'hDEAD_BEEF_0000_0001);
    do_read("rd_010", 12'h010, 64'hDEAD_BEEF_0000_0001, 1'b0);
    step();
    chk("hold_valid", data_t'(bus.rd_valid), '0);
    chk("hold_data", bus.data_out, 64'hDEAD_BEEF_0000_0001);
    chk("hold_uninit", data_t'(bus.rd_uninit), '0);

    // Same-edge write/read bypass over an old value
    do_write(12'h0AB, 64'h5555);
    bus.write       = 1'b1;
    bus.wrt_address = 12'h0AB;
    bus.data_in     = 64'h1234;
    do_read("bypass_0ab", 12'h0AB, 64'h1234, 1'b0);

    // Bypass to a never-written address reports written data, not uninit
    bus.write       = 1'b1;
    bus.wrt_address = 12'h0CC;
    bus.data_in     = 64'h77;
    do_read("bypass_0cc", 12'h0CC, 64'h77, 1'b0);

    // Write after capture must not alter the captured read
    do_write(12'h020, 64'h1);
    bus.read       = 1'b1;
    bus.rd_address = 12'h020;
    step();
    bus.read        = 1'b0;
    bus.write       = 1'b1;
    bus.wrt_address = 12'h020;
    bus.data_in     = 64'h2;
    step();
    bus.write = 1'b0;
    chk("late_wr_valid", data_t'(bus.rd_valid), 64'h1);
    chk("late_wr_data", bus.data_out, 64'h1);
    do_read("rd_020_new", 12'h020, 64'h2, 1'b0);

    // Back-to-back reads 0..7 with concurrent writes elsewhere
    for (int i = 0; i < 8; i++) do_write(addr_t'(i), data_t'(i));
    for (int i = 0; i < 10; i++) begin
      bus.read        = (i < 8);
      bus.rd_address  = addr_t'(i);
      bus.write       = (i < 8);
      bus.wrt_address = addr_t'(12'h300 + i);
      bus.data_in     = data_t'(8'hA0 + i);
      step();
      if (i >= 1 && i <= 8) begin
        chk($sformatf("b2b_valid%0d", i - 1), data_t'(bus.rd_valid), 64'h1);
        chk($sformatf("b2b_data%0d", i - 1), bus.data_out, data_t'(i - 1));
      end
    end
    chk("b2b_end_valid", data_t'(bus.rd_valid), '0);
    chk("b2b_end_hold", bus.data_out, 64'h7);
    idle();
    do_read("indep_303", 12'h303, 64'hA3, 1'b0);

    // Reset with two reads in flight; writes during reset are dropped
    bus.read       = 1'b1;
    bus.rd_address = 12'h010;
    step();
    bus.rd_address = 12'h020;
    step();
    resetn = 1'b0;
    bus.read = 1'b0;
    #1;
    chk("midrst_valid", data_t'(bus.rd_valid), '0);
    chk("midrst_data", bus.data_out, '0);
    bus.write       = 1'b1;
    bus.wrt_address = 12'h050;
    bus.data_in     = 64'hBAD;
    step(); step();
    bus.wrt_address = 12'h060;
    bus.data_in     = 64'h600D;
    resetn = 1'b1;
    step();
    bus.write = 1'b0;
    chk("post_rst_valid0", data_t'(bus.rd_valid), '0);
    step();
    chk("post_rst_valid1", data_t'(bus.rd_valid), '0);
    step();
    chk("post_rst_valid2", data_t'(bus.rd_valid), '0);
    do_read("post_rst_010", 12'h010, '0, 1'b1);
    do_read("rst_wr_050", 12'h050, '0, 1'b1);
    do_read("first_edge_060", 12'h060, 64'h600D, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_dual_port_ram
